// File: rtl/wght_fetch_sched_pkg.sv
// Shared types for the weight-fetch scheduler: weight word type, FSM states and default BRAM depth.
package snn_wght_pkg;

    typedef shortreal wght_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } fetch_st_e;

    localparam int RAM_DEPTH_DEF = 32;

endpackage

// File: rtl/wght_fetch_sched_if.sv
// Requester-side burst request / weight response bundle between the neuron array and the scheduler.
interface wght_fetch_sched_if
    import snn_wght_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6
) ();

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][ADDR_W-1:0] req_base;
    logic [N_REQ-1:0][LEN_W-1:0]  req_len;
    logic [N_REQ-1:0]             rsp_valid;
    wght_t                        rsp_data;
    logic                         rsp_last;

    modport master (
        output req_valid, req_base, req_len,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_base, req_len,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );

endinterface

// File: rtl/wght_fetch_sched_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr (mod N) wins.
module rr_arb #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                any     = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = PW'(k);
            end
        end
    end

endmodule

// File: rtl/wght_fetch_sched.sv
// Round-robin burst scheduler sharing one 1-cycle-latency weight BRAM among N_REQ requesters.
// Optional per-requester grant/wait counters when WGHT_FETCH_STATS_EN is defined.
module wght_fetch_sched
    import snn_wght_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int ADDR_W    = $clog2(RAM_DEPTH),
    parameter int LEN_W     = $clog2(RAM_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    wght_fetch_sched_if.slave rq,
    output logic              bram_ren,
    output logic [ADDR_W-1:0] bram_raddr,
    input  wght_t             bram_rdat,
    output logic              busy
`ifdef WGHT_FETCH_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0] stat_grants,
    output logic [N_REQ-1:0][31:0] stat_wait
`endif
);

    localparam int                PW       = $clog2(N_REQ);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(RAM_DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [PW-1:0]     PTR_TOP  = PW'(N_REQ - 1);

    fetch_st_e         state, state_n;
    logic [PW-1:0]     rr_ptr, rr_ptr_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [LEN_W-1:0]  rem, rem_n;
    logic [N_REQ-1:0]  own, own_n;
    logic [N_REQ-1:0]  tag_q, tag_n;
    logic              last_q, last_n;

    logic [N_REQ-1:0]  ready;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [LEN_W-1:0]  glen;
    logic [N_REQ-1:0]  rsp_vld;

    logic [N_REQ-1:0]  gnt;
    logic [PW-1:0]     gidx;
    logic              gany;

    rr_arb #(.N(N_REQ)) u_arb (
        .req     (rq.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gidx),
        .any     (gany)
    );

    // Explicit wrap so non-power-of-2 depths never address past the last entry.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_TOP) ? '0 : a + ADDR_W'(1);
    endfunction

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        addr_n   = addr;
        rem_n    = rem;
        own_n    = own;
        tag_n    = '0;
        last_n   = 1'b0;
        ready    = '0;
        ren      = 1'b0;
        raddr    = '0;
        glen     = (rq.req_len[gidx] > LEN_MAX) ? LEN_MAX : rq.req_len[gidx];
        case (state)
            IDLE: begin
                if (gany) begin
                    ready    = gnt;
                    rr_ptr_n = (gidx == PTR_TOP) ? '0 : gidx + PW'(1);
                    // Beat 0 goes out in the grant cycle so back-to-back single beats leave no gap.
                    if (glen != '0) begin
                        ren    = 1'b1;
                        raddr  = rq.req_base[gidx];
                        tag_n  = gnt;
                        last_n = (glen == LEN_ONE);
                        if (glen != LEN_ONE) begin
                            state_n = BURST;
                            rem_n   = glen - LEN_ONE;
                            addr_n  = addr_inc(rq.req_base[gidx]);
                            own_n   = gnt;
                        end
                    end
                end
            end
            BURST: begin
                ren    = 1'b1;
                raddr  = addr;
                tag_n  = own;
                last_n = (rem == LEN_ONE);
                addr_n = addr_inc(addr);
                rem_n  = rem - LEN_ONE;
                if (rem == LEN_ONE) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            addr   <= '0;
            rem    <= '0;
            own    <= '0;
            tag_q  <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            addr   <= addr_n;
            rem    <= rem_n;
            own    <= own_n;
            tag_q  <= tag_n;
            last_q <= last_n;
        end
    end

    // Outputs held at their idle values while rst is high; an in-flight beat is dropped.
    assign rq.req_ready = rst ? '0 : ready;
    assign bram_ren     = ren & ~rst;
    assign bram_raddr   = rst ? '0 : raddr;
    assign rsp_vld      = rst ? '0 : tag_q;
    assign rq.rsp_valid = rsp_vld;
    assign rq.rsp_last  = last_q & ~rst;

    always_comb begin
        rq.rsp_data = (|rsp_vld) ? bram_rdat : 0.0;
    end

    assign busy = ((state == BURST) & ~rst) | (|rsp_vld) | bram_ren;

`ifdef WGHT_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_wait   <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rq.req_valid[i] && ready[i] && (stat_grants[i] != '1))
                    stat_grants[i] <= stat_grants[i] + 32'd1;
                if (rq.req_valid[i] && !ready[i] && (stat_wait[i] != '1))
                    stat_wait[i] <= stat_wait[i] + 32'd1;
            end
        end
    end
`endif

endmodule
